seq_nibble_comparator: RTL and testbench

//  Multi-cycle magnitude comparator for wide operands. Walks A/B one 4-bit nibble per clock,
//  MSB nibble first, applying the same gt/eq/lt cascade rule as our 4-bit comparator slice.

---
 rtl/seq_nibble_comparator.sv | 207 ++++++++++++++++++++
 tb/tb_seq_nibble_comparator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_nibble_comparator.sv
// rtl/seq_nibble_comparator.sv - multi-cycle nibble-serial magnitude comparator
//
// Purpose:
//    Compares two unsigned WIDTH-bit operands one 4-bit nibble per clock,
//    most-significant nibble first, using the gt/eq/lt cascade rule of the
//    4-bit comparator slice. When every nibble is equal, the captured cascade
//    inputs become the result unchanged, so illegal cascade combinations also
//    pass through unchanged. Operands are captured on accept, so later
//    changes on a/b/cascade have no effect on a comparison in flight.
//
// Parameters:
//    WIDTH       operand width in bits (multiple of 4, >= 4)
//    EARLY_EXIT  1: finish at the first unequal nibble; 0: always scan all nibbles
//
// Ports:
//    clk        in   1      clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      operand/cascade bundle valid
//    in_ready   out  1      bundle can be accepted (state is IDLE)
//    a, b       in   WIDTH  operands, unsigned
//    iagtb      in   1      cascade-in A>B
//    iaeqb      in   1      cascade-in A==B
//    ialtb      in   1      cascade-in A<B
//    out_valid  out  1      result valid (registered)
//    out_ready  in   1      consumer accepts result
//    oagtb      out  1      result A>B (registered)
//    oaeqb      out  1      result A==B (registered)
//    oaltb      out  1      result A<B (registered)
//    busy       out  1      comparison in progress or result pending

`timescale 1ns/1ps

module seq_nibble_comparator #(
   parameter int WIDTH      = 12,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             iagtb,
   input  logic             iaeqb,
   input  logic             ialtb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             oagtb,
   output logic             oaeqb,
   output logic             oaltb,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_casc;       // {gt, eq, lt}
   logic             r_dec;        // a nibble has already decided the result
   logic [2:0]       r_dec_res;    // result chosen by that nibble
   logic [2:0]       r_res;        // {gt, eq, lt} presented on the outputs
   logic             r_out_valid;

   logic [3:0]       w_nib_a;
   logic [3:0]       w_nib_b;
   logic             w_nib_gt;
   logic             w_nib_lt;
   logic             w_last;
   logic             w_dec_nxt;
   logic [2:0]       w_dec_res_nxt;
   logic [2:0]       w_final_res;
   logic             w_finish;

   // Select the nibble at r_idx from the captured operands.
   always_comb begin
      w_nib_a = '0;
      w_nib_b = '0;
      for (int i = 0; i < NIB; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib_a = r_a[4*i +: 4];
            w_nib_b = r_b[4*i +: 4];
         end
      end
   end

   // Cascade rule for the current nibble. Once a more-significant nibble has
   // decided, the decision is sticky and the remaining nibbles are ignored.
   always_comb begin
      w_nib_gt      = (w_nib_a > w_nib_b);
      w_nib_lt      = (w_nib_a < w_nib_b);
      w_last        = (r_idx == '0);
      w_dec_nxt     = r_dec;
      w_dec_res_nxt = r_dec_res;
      if (!r_dec) begin
         if (w_nib_gt) begin
            w_dec_nxt     = 1'b1;
            w_dec_res_nxt = 3'b100;
         end else if (w_nib_lt) begin
            w_dec_nxt     = 1'b1;
            w_dec_res_nxt = 3'b001;
         end
      end
      // All nibbles equal: the cascade bits pass through untouched.
      w_final_res = w_dec_nxt ? w_dec_res_nxt : r_casc;
      w_finish    = EARLY_EXIT ? (w_dec_nxt || w_last) : w_last;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = S_CMP;
            end
         end
         S_CMP: begin
            if (w_finish) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // out_valid is always 1 in DONE, so out_ready alone completes it.
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, nibble walk and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= IDX_TOP;
         r_a         <= '0;
         r_b         <= '0;
         r_casc      <= '0;
         r_dec       <= 1'b0;
         r_dec_res   <= '0;
         r_res       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_casc    <= {iagtb, iaeqb, ialtb};
                  r_idx     <= IDX_TOP;
                  r_dec     <= 1'b0;
                  r_dec_res <= '0;
               end
            end
            S_CMP: begin
               if (w_finish) begin
                  r_res       <= w_final_res;
                  r_out_valid <= 1'b1;
               end else begin
                  r_idx     <= r_idx - IW'(1);
                  r_dec     <= w_dec_nxt;
                  r_dec_res <= w_dec_res_nxt;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign oagtb     = r_res[2];
   assign oaeqb     = r_res[1];
   assign oaltb     = r_res[0];

endmodule

// File: tb/tb_seq_nibble_comparator.sv
// tb/tb_seq_nibble_comparator.sv - self-checking bench for seq_nibble_comparator

`timescale 1ns/1ps

module tb_seq_nibble_comparator;

   localparam int WIDTH = 12;
   localparam int NIB   = WIDTH / 4;
   localparam int TMO   = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       casc;

   // dut1: EARLY_EXIT=1, dut0: EARLY_EXIT=0; operands are shared.
   logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [2:0] res1;
   logic       in_valid0, in_ready0, out_valid0, out_ready0, busy0;
   logic [2:0] res0;

   int n_tests = 0;
   int n_fail  = 0;

   seq_nibble_comparator #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a), .b(b),
      .iagtb(casc[2]), .iaeqb(casc[1]), .ialtb(casc[0]),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .oagtb(res1[2]), .oaeqb(res1[1]), .oaltb(res1[0]),
      .busy(busy1)
   );

   seq_nibble_comparator #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .a(a), .b(b),
      .iagtb(casc[2]), .iaeqb(casc[1]), .ialtb(casc[0]),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .oagtb(res0[2]), .oaeqb(res0[1]), .oaltb(res0[0]),
      .busy(busy0)
   );

   // Reference: whole-operand magnitude compare, cascade on equality.
   function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic [2:0] c);
      if (x > y) return 3'b100;
      if (x < y) return 3'b001;
      return c;
   endfunction

   // Reference latency: nibbles down to (and including) the highest differing one.
   function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input bit ee);
      logic [WIDTH-1:0] d;
      int p;
      d = x ^ y;
      p = -1;
      if (!ee) return NIB;
      for (int i = 0; i < WIDTH; i++) if (d[i]) p = i;
      if (p < 0) return NIB;
      return NIB - p / 4;
   endfunction

   // Issue one bundle to the chosen DUT and wait for out_valid. Live inputs are
   // scrambled right after acceptance. Returns cycles after E0 and the result.
   task automatic run_txn(input bit ee, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [2:0] tc, output int lat, output logic [2:0] res,
                          output bit acc_ok, output bit done_ok);
      @(negedge clk);
      a = ta; b = tb_v; casc = tc;
      if (ee) in_valid1 = 1'b1; else in_valid0 = 1'b1;
      acc_ok = ee ? in_ready1 : in_ready0;
      @(posedge clk); #1;
      in_valid1 = 1'b0; in_valid0 = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); casc = 3'($urandom);
      lat = 0; res = 3'bxxx; done_ok = 1'b0;
      while (!done_ok && lat < TMO) begin
         @(posedge clk); #1;
         lat++;
         if (ee ? out_valid1 : out_valid0) begin
            done_ok = 1'b1;
            res = ee ? res1 : res0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid1 = 1'b0; in_valid0 = 1'b0;
      out_ready1 = 1'b1; out_ready0 = 1'b1;
      a = '0; b = '0; casc = 3'b010;
      #12;
      n_tests++;
      if ({out_valid1, res1, busy1, in_ready1} !== 6'b0_000_0_1) begin
         n_fail++;
         $display("FAIL reset_ee1: got %b expected 000001", {out_valid1, res1, busy1, in_ready1});
      end
      n_tests++;
      if ({out_valid0, res0, busy0, in_ready0} !== 6'b0_000_0_1) begin
         n_fail++;
         $display("FAIL reset_ee0: got %b expected 000001", {out_valid0, res0, busy0, in_ready0});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid1, busy1, in_ready1} !== 3'b001) begin
         n_fail++;
         $display("FAIL reset_release: got %b expected 001", {out_valid1, busy1, in_ready1});
      end
   endtask

   task automatic test_directed();
      int lat; logic [2:0] res; bit acc_ok, done_ok;
      logic [WIDTH-1:0] ta [5]    = '{12'h5A3, 12'h123, 12'hABC, 12'hABC, 12'h5A3};
      logic [WIDTH-1:0] tbv [5]   = '{12'h4FF, 12'h124, 12'hABC, 12'hABC, 12'h4FF};
      logic [2:0]       tc [5]    = '{3'b010, 3'b010, 3'b100, 3'b010, 3'b010};
      bit               tee [5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0]       eres [5]  = '{3'b100, 3'b001, 3'b100, 3'b010, 3'b100};
      int               elat [5]  = '{1, 3, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
         run_txn(tee[i], ta[i], tbv[i], tc[i], lat, res, acc_ok, done_ok);
         n_tests++;
         if (!acc_ok || !done_ok || res !== eres[i] || lat != elat[i]) begin
            n_fail++;
            $display("FAIL directed_%0d: got acc=%0b done=%0b res=%b lat=%0d expected acc=1 done=1 res=%b lat=%0d",
                     i, acc_ok, done_ok, res, lat, eres[i], elat[i]);
         end
         @(posedge clk); #1;
         n_tests++;
         if ((tee[i] ? {out_valid1, in_ready1} : {out_valid0, in_ready0}) !== 2'b01) begin
            n_fail++;
            $display("FAIL directed_%0d_release: got ov/ir=%b expected 01", i,
                     tee[i] ? {out_valid1, in_ready1} : {out_valid0, in_ready0});
         end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready1 = 1'b0;
      a = 12'h5A3; b = 12'h4FF; casc = 3'b010; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid1, res1} !== 4'b1_100) begin
         n_fail++;
         $display("FAIL bp_first: got %b expected 1100", {out_valid1, res1});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid1 = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
         n_tests++;
         if ({out_valid1, res1, in_ready1, busy1} !== 6'b1_100_0_1) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got %b expected 110001", i, {out_valid1, res1, in_ready1, busy1});
         end
      end
      @(negedge clk);
      in_valid1 = 1'b0; out_ready1 = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid1, in_ready1, busy1, res1} !== 6'b0_1_0_100) begin
         n_fail++;
         $display("FAIL bp_release: got %b expected 010100", {out_valid1, in_ready1, busy1, res1});
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if ({out_valid1, busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_no_accept_%0d: got %b expected 00", i, {out_valid1, busy1});
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [2:0] res; bit acc_ok, done_ok;
      @(negedge clk);
      a = 12'h123; b = 12'h124; casc = 3'b010; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({busy1, out_valid1} !== 2'b10) begin
         n_fail++;
         $display("FAIL rstmid_in_cmp: got %b expected 10", {busy1, out_valid1});
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid1, res1, busy1, in_ready1} !== 6'b0_000_0_1) begin
         n_fail++;
         $display("FAIL rstmid_async: got %b expected 000001", {out_valid1, res1, busy1, in_ready1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      n_tests++;
      if (out_valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_no_result: got %b expected 0", out_valid1);
      end
      run_txn(1'b1, 12'h5A3, 12'h4FF, 3'b010, lat, res, acc_ok, done_ok);
      n_tests++;
      if (!acc_ok || !done_ok || res !== 3'b100 || lat != 1) begin
         n_fail++;
         $display("FAIL rstmid_after: got acc=%0b done=%0b res=%b lat=%0d expected 1 1 100 1",
                  acc_ok, done_ok, res, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat; logic [2:0] res; bit acc_ok, done_ok;
      logic [WIDTH-1:0] ta, tbv; logic [2:0] tc; bit ee; int n;
      for (int i = 0; i < 80; i++) begin
         ee = (i % 2 == 0);
         ta = WIDTH'($urandom);
         tbv = ta;
         case ($urandom_range(0, 3))
            0: tbv = WIDTH'($urandom);
            1: ;
            default: begin
               n = $urandom_range(0, NIB - 1);
               tbv[4*n +: 4] = 4'($urandom);
            end
         endcase
         tc = 3'($urandom);
         run_txn(ee, ta, tbv, tc, lat, res, acc_ok, done_ok);
         n_tests++;
         if (!acc_ok || !done_ok || res !== ref_res(ta, tbv, tc) || lat != ref_lat(ta, tbv, ee)) begin
            n_fail++;
            $display("FAIL random_%0d ee=%0b a=%h b=%h c=%b: got res=%b lat=%0d acc=%0b done=%0b expected res=%b lat=%0d",
                     i, ee, ta, tbv, tc, res, lat, acc_ok, done_ok, ref_res(ta, tbv, tc), ref_lat(ta, tbv, ee));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] q [$];
      logic [2:0] exp_r;
      int accepted;
      accepted = 0;
      for (int cyc = 0; cyc < 300 + TMO; cyc++) begin
         @(negedge clk);
         if (cyc < 300) begin
            in_valid1 = 1'b1;
            out_ready1 = 1'($urandom_range(0, 1));
            a = WIDTH'($urandom); b = WIDTH'($urandom); casc = 3'($urandom);
            if ($urandom_range(0, 2) == 0) b = a;
         end else begin
            in_valid1 = 1'b0;
            out_ready1 = 1'b1;
         end
         if (out_valid1 && in_ready1) begin
            n_tests++; n_fail++;
            $display("FAIL b2b_overlap: got out_valid=1 in_ready=1 expected not both");
         end
         if (in_valid1 && in_ready1) begin
            q.push_back(ref_res(a, b, casc));
            accepted++;
         end
         if (out_valid1 && out_ready1) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_extra: got result %b expected none", res1);
            end else begin
               exp_r = q.pop_front();
               if (res1 !== exp_r) begin
                  n_fail++;
                  $display("FAIL b2b_result: got %b expected %b", res1, exp_r);
               end
            end
         end
      end
      n_tests++;
      if (q.size() != 0 || accepted < 20) begin
         n_fail++;
         $display("FAIL b2b_drain: got pending=%0d accepted=%0d expected 0 and >=20", q.size(), accepted);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
